// File: rtl/rrat.sv
// Retirement register alias table: committed ARF->PRF map and committed PRF free list.
module rrat #(
  parameter int unsigned ARF_width = 5,
  parameter int unsigned PRF_size  = 64,
  parameter int unsigned PRF_width = 6
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ARF_width-1:0]    ROB_ARF_num_in,
  input  logic [PRF_width-1:0]    ROB_PRF_num_in,
  input  logic                    ROB_commit_in,
  output logic [PRF_size-1:0]     RRAT_PRF_FL_out,
  output logic [32*PRF_width-1:0] RRAT_copy_out,
  output logic [PRF_width-1:0]    RRAT_free_PRF_num_out
);

  localparam int unsigned ARF_count = 32;

  // The first ARF_count PRFs start out mapped, the rest start free.
  localparam logic [PRF_size-1:0] FL_reset =
    {{(PRF_size-ARF_count){1'b1}}, {ARF_count{1'b0}}};

  logic [PRF_width-1:0] map_q [ARF_count];
  logic [PRF_size-1:0]  free_q;
  logic [PRF_width-1:0] old_prf;

  // Mapping being displaced by the retiring instruction.
  assign old_prf = map_q[ROB_ARF_num_in];

  // Map and free-list update; the clear of the new PRF is written last so it
  // wins when the new PRF equals the displaced one.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ARF_count; i++) begin
        map_q[i] <= PRF_width'(i);
      end
      free_q <= FL_reset;
    end else if (ROB_commit_in) begin
      map_q[ROB_ARF_num_in] <= ROB_PRF_num_in;
      free_q[old_prf]       <= 1'b1;
      free_q[ROB_PRF_num_in] <= 1'b0;
    end
  end

  // Flatten the map for restore by the front-end RAT.
  for (genvar g = 0; g < ARF_count; g++) begin : g_copy
    assign RRAT_copy_out[g*PRF_width +: PRF_width] = map_q[g];
  end

  assign RRAT_PRF_FL_out       = free_q;
  assign RRAT_free_PRF_num_out = old_prf;

endmodule

// File: tb/tb_rrat.sv
// Directed self-checking bench for rrat.
module tb_rrat;

  logic         clock;
  logic         reset;
  logic [4:0]   arf;
  logic [5:0]   prf;
  logic         commit;
  logic [63:0]  fl;
  logic [191:0] copy;
  logic [5:0]   free_num;

  int checks;
  int failures;

  logic [191:0] copy_rst;
  logic [63:0]  fl_rst;

  rrat dut (
    .clock                 (clock),
    .reset                 (reset),
    .ROB_ARF_num_in        (arf),
    .ROB_PRF_num_in        (prf),
    .ROB_commit_in         (commit),
    .RRAT_PRF_FL_out       (fl),
    .RRAT_copy_out         (copy),
    .RRAT_free_PRF_num_out (free_num)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count a comparison and report a mismatch.
  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle past it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [5:0] entry(input int i);
    return copy[i*6 +: 6];
  endfunction

  task automatic do_reset();
    reset = 1'b1; commit = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    for (int i = 0; i < 32; i++) copy_rst[i*6 +: 6] = 6'(i);
    fl_rst = 64'hFFFF_FFFF_0000_0000;
    reset = 1'b0; commit = 1'b0; arf = '0; prf = '0;
    #2;

    // Reset state
    do_reset();
    check("rst_copy", copy, copy_rst);
    check("rst_fl", 192'(fl), 192'(fl_rst));

    // First commit ARF0 -> PRF63
    commit = 1'b1; arf = 5'd0; prf = 6'd63;
    #1 check("c1_free_num", 192'(free_num), 192'd0);
    tick(); commit = 1'b0;
    check("c1_entry0", 192'(entry(0)), 192'd63);
    check("c1_fl63", 192'(fl[63]), 192'd0);
    check("c1_fl0", 192'(fl[0]), 192'd1);

    // Idle cycle with arbitrary inputs
    arf = 5'd7; prf = 6'd9;
    #1 check("idle_free_num", 192'(free_num), 192'd7);
    tick();
    check("idle_entry0", 192'(entry(0)), 192'd63);
    check("idle_entry7", 192'(entry(7)), 192'd7);
    check("idle_fl", 192'(fl), 192'(64'hFFFF_FFFF_0000_0000 ^ 64'h8000_0000_0000_0001));

    // Re-commit ARF0 -> PRF1 (aliases ARF1)
    commit = 1'b1; arf = 5'd0; prf = 6'd1;
    #1 check("c2_free_num", 192'(free_num), 192'd63);
    tick(); commit = 1'b0;
    check("c2_entry0", 192'(entry(0)), 192'd1);
    check("c2_fl63", 192'(fl[63]), 192'd1);
    check("c2_fl1", 192'(fl[1]), 192'd0);
    check("c2_entry1", 192'(entry(1)), 192'd1);
    check("c2_fl0", 192'(fl[0]), 192'd1);

    // Self-map commit ARF5 -> PRF5 from reset
    do_reset();
    commit = 1'b1; arf = 5'd5; prf = 6'd5;
    #1 check("self_free_num", 192'(free_num), 192'd5);
    tick(); commit = 1'b0;
    check("self_copy", copy, copy_rst);
    check("self_fl", 192'(fl), 192'(fl_rst));

    // Back-to-back commits to ARF3 chain
    commit = 1'b1; arf = 5'd3; prf = 6'd33;
    #1 check("bb1_free_num", 192'(free_num), 192'd3);
    tick();
    prf = 6'd34;
    #1 check("bb2_free_num", 192'(free_num), 192'd33);
    tick(); commit = 1'b0;
    check("bb_entry3", 192'(entry(3)), 192'd34);
    check("bb_fl", 192'(fl), 192'(64'hFFFF_FFFB_0000_0008));

    // ARF31 updates like any other
    commit = 1'b1; arf = 5'd31; prf = 6'd50;
    #1 check("a31_free_num", 192'(free_num), 192'd31);
    tick(); commit = 1'b0;
    check("a31_entry31", 192'(entry(31)), 192'd50);
    check("a31_fl", 192'(fl), 192'(64'hFFFB_FFFB_8000_0008));

    // Reset wins over a simultaneous commit
    reset = 1'b1; commit = 1'b1; arf = 5'd2; prf = 6'd40;
    tick();
    reset = 1'b0; commit = 1'b0;
    check("rp_copy", copy, copy_rst);
    check("rp_fl", 192'(fl), 192'(fl_rst));
    check("rp_entry2", 192'(entry(2)), 192'd2);
    check("rp_fl40", 192'(fl[40]), 192'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
